// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: frequency codes, divisors and FSM state shared by the frequency meter.
package freq_meter_pkg;
    localparam logic [1:0] FREQ_1HZ  = 2'd0;
    localparam logic [1:0] FREQ_2HZ  = 2'd1;
    localparam logic [1:0] FREQ_5HZ  = 2'd2;
    localparam logic [1:0] FREQ_10HZ = 2'd3;
    localparam int DIV_1HZ  = 1;
    localparam int DIV_2HZ  = 2;
    localparam int DIV_5HZ  = 5;
    localparam int DIV_10HZ = 10;
    typedef enum logic {IDLE, RUN} state_t;
    function automatic int divisor(input logic [1:0] code);
        return code == FREQ_1HZ ? DIV_1HZ : code == FREQ_2HZ ? DIV_2HZ :
               code == FREQ_5HZ ? DIV_5HZ : DIV_10HZ;
    endfunction
endpackage

// File: rtl/freq_meter_if.sv
// freq_meter_if: square-wave input and measurement results of the frequency meter.
interface freq_meter_if #(parameter int CW = 28);
    logic          sig_in;
    logic [1:0]    sel_freq_det;
    logic [CW-1:0] period;
    logic          valid;
    logic          match;
    logic          locked;
    logic          no_signal;
    modport master (output sig_in, input sel_freq_det, period, valid, match, locked, no_signal);
    modport slave  (input sig_in, output sel_freq_det, period, valid, match, locked, no_signal);
endinterface

// File: rtl/edge_sync.sv
// edge_sync: 2-flop synchronizer plus a third flop giving a one-cycle rising-edge pulse.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic e_o
);
    logic [2:0] s_q;
    always_ff @(posedge clk) begin
        if (rst) s_q <= '0;
        else     s_q <= {s_q[1:0], d_i};
    end
    assign e_o = s_q[1] & ~s_q[2];
endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts clocks between rising edges of sig_in, classifies the period
// into one of the 1/2/5/10 Hz codes and tracks lock and loss of signal.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int SYS_FREQ  = 100_000_000,
    parameter int TOL_SHIFT = 6,
    parameter int CW        = $clog2(2*SYS_FREQ+1)
) (
    input  logic clk,
    input  logic rst,
    freq_meter_if.slave bus
);
    localparam logic [CW-1:0] TIMEOUT = CW'(2*SYS_FREQ);

    logic          e;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, period_q, period_d;
    logic          valid_q, valid_d, match_q, match_d, locked_q, locked_d;
    logic          cand_v_q, cand_v_d, nosig_q, nosig_d;
    logic [1:0]    sel_q, sel_d, cand_q, cand_d, code;
    logic [3:0]    hit;

    edge_sync u_sync (.clk(clk), .rst(rst), .d_i(bus.sig_in), .e_o(e));

    for (genvar g = 0; g < 4; g++) begin : g_win
        localparam int P = SYS_FREQ / divisor(2'(g));
        localparam int T = P >> TOL_SHIFT;
        assign hit[g] = cnt_q >= CW'(P - T) && cnt_q <= CW'(P + T);
    end

    // lowest code wins when windows overlap
    assign code = hit[0] ? FREQ_1HZ : hit[1] ? FREQ_2HZ : hit[2] ? FREQ_5HZ : FREQ_10HZ;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = 1'b0;
        match_d  = match_q;
        locked_d = locked_q;
        sel_d    = sel_q;
        cand_d   = cand_q;
        cand_v_d = cand_v_q;
        nosig_d  = nosig_q;
        if (state_q == IDLE) begin
            if (e) begin
                state_d = RUN;
                cnt_d   = CW'(1);
                nosig_d = 1'b0;
            end
        end else if (e) begin
            cnt_d    = CW'(1);
            period_d = cnt_q;
            valid_d  = 1'b1;
            match_d  = |hit;
            if (!(|hit)) begin
                cand_v_d = 1'b0;
                locked_d = 1'b0;
            end else if (cand_v_q && code == cand_q) begin
                locked_d = 1'b1;
                sel_d    = code;
            end else begin
                cand_d   = code;
                cand_v_d = 1'b1;
                locked_d = 1'b0;
            end
        end else if (cnt_q == TIMEOUT) begin
            state_d  = IDLE;
            nosig_d  = 1'b1;
            locked_d = 1'b0;
            cand_v_d = 1'b0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            match_q  <= 1'b0;
            locked_q <= 1'b0;
            sel_q    <= FREQ_1HZ;
            cand_q   <= FREQ_1HZ;
            cand_v_q <= 1'b0;
            nosig_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
            locked_q <= locked_d;
            sel_q    <= sel_d;
            cand_q   <= cand_d;
            cand_v_q <= cand_v_d;
            nosig_q  <= nosig_d;
        end
    end

    assign bus.sel_freq_det = sel_q;
    assign bus.period       = period_q;
    assign bus.valid        = valid_q;
    assign bus.match        = match_q;
    assign bus.locked       = locked_q;
    assign bus.no_signal    = nosig_q;
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: table-driven check of the frequency meter with SYS_FREQ=1000, TOL_SHIFT=4.
module tb_freq_meter;
    localparam int SF = 1000;
    localparam int CW = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    freq_meter_if #(.CW(CW)) bus ();
    freq_meter #(.SYS_FREQ(SF), .TOL_SHIFT(4), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // each row: this rising edge is followed n cycles later by the next one;
    // expectations describe the result produced by this row's edge (measuring the previous n)
    typedef struct {
        int         n;
        bit         v;
        logic       m;
        logic       l;
        logic [1:0] s;
        logic       ns;
    } row_t;

    int tests = 0, fails = 0, cyc = 0, vcnt = 0, vexp = 0, vcyc = 0, prev_n = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.valid) vcnt <= vcnt + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " period"}, int'(bus.period), 0);
        chk({tag, " valid"}, int'(bus.valid), 0);
        chk({tag, " match"}, int'(bus.match), 0);
        chk({tag, " locked"}, int'(bus.locked), 0);
        chk({tag, " sel"}, int'(bus.sel_freq_det), 0);
        chk({tag, " no_signal"}, int'(bus.no_signal), 1);
    endtask

    task automatic apply(input row_t r, input string tag);
        bit seen;
        seen = 1'b0;
        bus.sig_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.valid) begin
                seen = 1'b1;
                vcyc = cyc;
            end
        end
        chk({tag, " valid"}, int'(seen), int'(r.v));
        chk({tag, " no_signal"}, int'(bus.no_signal), int'(r.ns));
        chk({tag, " locked"}, int'(bus.locked), int'(r.l));
        if (r.v) begin
            vexp++;
            chk({tag, " period"}, int'(bus.period), prev_n);
            chk({tag, " match"}, int'(bus.match), int'(r.m));
            chk({tag, " sel"}, int'(bus.sel_freq_det), int'(r.s));
        end
        repeat (r.n / 2 - 4) @(negedge clk);
        bus.sig_in = 1'b0;
        repeat (r.n - r.n / 2) @(negedge clk);
        prev_n = r.n;
    endtask

    row_t ta [13] = '{
        '{500,  0, 0, 0, 0, 0},
        '{500,  1, 1, 0, 0, 0},
        '{200,  1, 1, 1, 1, 0},
        '{200,  1, 1, 0, 1, 0},
        '{212,  1, 1, 1, 2, 0},
        '{213,  1, 1, 1, 2, 0},
        '{1062, 1, 0, 0, 2, 0},
        '{1063, 1, 1, 0, 2, 0},
        '{937,  1, 0, 0, 2, 0},
        '{938,  1, 0, 0, 2, 0},
        '{100,  1, 1, 0, 2, 0},
        '{100,  1, 1, 0, 2, 0},
        '{100,  1, 1, 1, 3, 0}
    };
    row_t tb_rows [5] = '{
        '{100,  0, 0, 0, 3, 0},
        '{100,  1, 1, 0, 3, 0},
        '{1000, 1, 1, 1, 3, 0},
        '{1000, 1, 1, 0, 3, 0},
        '{1000, 1, 1, 1, 0, 0}
    };
    row_t tc [3] = '{
        '{500, 0, 0, 0, 0, 0},
        '{500, 1, 1, 0, 0, 0},
        '{500, 1, 1, 1, 1, 0}
    };

    initial begin
        int w;
        bus.sig_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst = 1'b0;
        for (int i = 0; i < 13; i++) apply(ta[i], $sformatf("a%0d", i));
        w = 0;
        while (!bus.no_signal && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("timeout cycles", cyc - vcyc, 2000);
        chk("timeout locked", int'(bus.locked), 0);
        chk("timeout sel", int'(bus.sel_freq_det), 3);
        chk("timeout period", int'(bus.period), 100);
        for (int i = 0; i < 5; i++) apply(tb_rows[i], $sformatf("b%0d", i));
        chk("pre-reset locked", int'(bus.locked), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midrst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) apply(tc[i], $sformatf("c%0d", i));
        chk("valid count", vcnt, vexp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
